// File: rtl/l524_bootrom_ctrl.sv
// Boot ROM slave on ICB: synthesises a lui/addi/jr stub toward the strap-selected target, one-entry response buffer.
// Build macro L524_BOOTROM_WR_ERR_EN: when defined, writes are answered with err=1; otherwise they are silently dropped.
module l524_bootrom_ctrl #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          DATA_DEPTH = 1024,
  parameter logic [31:0] ITCM_BASE  = 32'h8000_0000,
  parameter logic [31:0] FLASH_BASE = 32'h2040_0000,
  parameter logic [31:0] ALT_BASE   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            boot_mode,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] icb_cmd_addr,
  input  logic                  icb_cmd_read,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic [DATA_WIDTH-1:0] icb_rsp_rdata,
  output logic                  icb_rsp_err,
  output logic                  boot_done,
  output logic [1:0]            boot_mode_q
);

  localparam int NW        = DATA_WIDTH / 32;
  localparam int BSHIFT    = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int BOOT_BEAT = 8 >> BSHIFT;
  localparam logic [31:0] PARK_WORD = 32'h0000_006f;
  localparam logic [31:0] JR_WORD   = 32'h0002_8067;

`ifdef L524_BOOTROM_WR_ERR_EN
  localparam logic WR_ERR = 1'b1;
`else
  localparam logic WR_ERR = 1'b0;
`endif

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  hit_q, hit_d;
  logic                  boot_done_q, boot_done_d;

  logic [31:0]           tgt;
  logic [19:0]           hi;
  logic [31:0]           w0, w1;
  logic [31:0]           beat_idx;
  logic [31:0]           widx;
  logic [31:0]           word;
  logic [DATA_WIDTH-1:0] rom_dat;
  logic                  oob;
  logic                  cmd_hs, rsp_hs;

  // lo is sign-extended by addi, so hi absorbs a carry from bit 11
  always_comb begin
    case (boot_mode_q)
      2'd0:    tgt = ITCM_BASE;
      2'd1:    tgt = FLASH_BASE;
      default: tgt = ALT_BASE;
    endcase
    hi = tgt[31:12] + {19'd0, tgt[11]};
    w0 = {hi, 12'h2b7};
    w1 = {tgt[11:0], 20'h28293};
  end

  always_comb begin
    rom_dat  = '0;
    oob      = 1'b0;
    widx     = '0;
    word     = '0;
    beat_idx = 32'(icb_cmd_addr >> BSHIFT);
    for (int k = 0; k < NW; k++) begin
      widx = beat_idx * 32'(NW) + 32'(k);
      if (widx >= 32'(DATA_DEPTH)) oob = 1'b1;
      word = '0;
      if (boot_mode_q == 2'd3) begin
        if (widx == 32'd0) word = PARK_WORD;
      end else begin
        case (widx)
          32'd0:   word = w0;
          32'd1:   word = w1;
          32'd2:   word = JR_WORD;
          default: word = '0;
        endcase
      end
      rom_dat[k*32 +: 32] = word;
    end
  end

  assign icb_cmd_ready = !rsp_valid_q || icb_rsp_ready;
  assign cmd_hs        = icb_cmd_valid && icb_cmd_ready;
  assign rsp_hs        = rsp_valid_q && icb_rsp_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    hit_d       = hit_q;
    boot_done_d = boot_done_q;
    if (rsp_hs && hit_q && !err_q && (boot_mode_q != 2'd3)) boot_done_d = 1'b1;
    if (cmd_hs) begin
      rsp_valid_d = 1'b1;
      err_d       = oob || (!icb_cmd_read && WR_ERR);
      rdata_d     = (icb_cmd_read && !oob) ? rom_dat : '0;
      hit_d       = icb_cmd_read && (beat_idx == 32'(BOOT_BEAT));
    end else if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      boot_mode_q <= boot_mode;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      hit_q       <= 1'b0;
      boot_done_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      hit_q       <= hit_d;
      boot_done_q <= boot_done_d;
    end
  end

  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rdata_q;
  assign icb_rsp_err   = err_q;
  assign boot_done     = boot_done_q;

endmodule

// File: tb/tb_l524_bootrom_ctrl.sv
// Bench for l524_bootrom_ctrl: three configurations share one stimulus stream and are checked against a spec-level model.
module tb_l524_bootrom_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  boot_mode = 2'd0;
  logic        cmd_valid = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic        cmd_read = 1'b1;
  logic        rsp_ready = 1'b1;

`ifdef L524_BOOTROM_WR_ERR_EN
  localparam logic WR_ERR = 1'b1;
`else
  localparam logic WR_ERR = 1'b0;
`endif

  logic        rdy_a, vld_a, err_a, done_a;
  logic        rdy_b, vld_b, err_b, done_b;
  logic        rdy_c, vld_c, err_c, done_c;
  logic [31:0] dat_a, dat_b;
  logic [63:0] dat_c;
  logic [1:0]  mq_a, mq_b, mq_c;

  l524_bootrom_ctrl u_a (
    .clk(clk), .rst(rst), .boot_mode(boot_mode),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(rdy_a), .icb_cmd_addr(cmd_addr), .icb_cmd_read(cmd_read),
    .icb_rsp_valid(vld_a), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(dat_a), .icb_rsp_err(err_a),
    .boot_done(done_a), .boot_mode_q(mq_a));

  l524_bootrom_ctrl #(.ALT_BASE(32'h0000_1800)) u_b (
    .clk(clk), .rst(rst), .boot_mode(boot_mode),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(rdy_b), .icb_cmd_addr(cmd_addr), .icb_cmd_read(cmd_read),
    .icb_rsp_valid(vld_b), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(dat_b), .icb_rsp_err(err_b),
    .boot_done(done_b), .boot_mode_q(mq_b));

  l524_bootrom_ctrl #(.DATA_WIDTH(64), .DATA_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .boot_mode(boot_mode),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(rdy_c), .icb_cmd_addr(cmd_addr), .icb_cmd_read(cmd_read),
    .icb_rsp_valid(vld_c), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(dat_c), .icb_rsp_err(err_c),
    .boot_done(done_c), .boot_mode_q(mq_c));

  logic        a_rdy[3], a_vld[3], a_err[3], a_done[3];
  logic [63:0] a_dat[3];
  logic [1:0]  a_mq[3];
  assign a_rdy[0] = rdy_a;  assign a_rdy[1] = rdy_b;  assign a_rdy[2] = rdy_c;
  assign a_vld[0] = vld_a;  assign a_vld[1] = vld_b;  assign a_vld[2] = vld_c;
  assign a_err[0] = err_a;  assign a_err[1] = err_b;  assign a_err[2] = err_c;
  assign a_done[0] = done_a; assign a_done[1] = done_b; assign a_done[2] = done_c;
  assign a_dat[0] = {32'h0, dat_a}; assign a_dat[1] = {32'h0, dat_b}; assign a_dat[2] = dat_c;
  assign a_mq[0] = mq_a;    assign a_mq[1] = mq_b;    assign a_mq[2] = mq_c;

  int vectors = 0;
  int miscompares = 0;
  int cmd_cnt = 0;
  int rsp_cnt = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: each configuration is a flat word array plus a one-deep response slot
  int          m_dw[3]    = '{32, 32, 64};
  int          m_depth[3] = '{1024, 1024, 4};
  logic [31:0] m_alt[3]   = '{32'h0, 32'h1800, 32'h0};
  logic        m_vld[3]   = '{1'b0, 1'b0, 1'b0};
  logic        m_err[3]   = '{1'b0, 1'b0, 1'b0};
  logic        m_done[3]  = '{1'b0, 1'b0, 1'b0};
  logic        m_hit[3]   = '{1'b0, 1'b0, 1'b0};
  logic [63:0] m_dat[3]   = '{64'h0, 64'h0, 64'h0};
  logic [1:0]  m_mode     = 2'd0;

  function automatic logic [31:0] spec_word(input int idx, input logic [1:0] mode, input logic [31:0] alt);
    logic [31:0] t;
    logic [19:0] hi;
    if (mode == 2'd3) return (idx == 0) ? 32'h0000_006f : 32'h0;
    t  = (mode == 2'd0) ? 32'h8000_0000 : (mode == 2'd1) ? 32'h2040_0000 : alt;
    hi = t[31:12] + 20'(t[11]);
    if (idx == 0) return {hi, 12'h000} | 32'h2b7;
    if (idx == 1) return ({20'h0, t[11:0]} << 20) | 32'h28293;
    if (idx == 2) return 32'h0002_8067;
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    int bpb, nw, beat, idx;
    bit hs_cmd, hs_rsp, oob;
    logic [63:0] dat;
    cyc_n++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_vld[i] = 1'b0; m_err[i] = 1'b0; m_done[i] = 1'b0; m_hit[i] = 1'b0; m_dat[i] = '0;
      end else begin
        hs_rsp = m_vld[i] && rsp_ready;
        hs_cmd = cmd_valid && (!m_vld[i] || rsp_ready);
        if (hs_rsp && m_hit[i] && !m_err[i] && m_mode != 2'd3) m_done[i] = 1'b1;
        if (hs_cmd) begin
          bpb  = m_dw[i] / 8;
          nw   = m_dw[i] / 32;
          beat = int'(cmd_addr) / bpb;
          oob  = 1'b0;
          dat  = '0;
          for (int k = 0; k < nw; k++) begin
            idx = beat * nw + k;
            if (idx >= m_depth[i]) oob = 1'b1;
            dat[32*k +: 32] = spec_word(idx, m_mode, m_alt[i]);
          end
          m_vld[i] = 1'b1;
          m_err[i] = oob || (!cmd_read && WR_ERR);
          m_dat[i] = (cmd_read && !oob) ? dat : 64'h0;
          m_hit[i] = cmd_read && (beat == 8 / bpb);
        end else if (hs_rsp) begin
          m_vld[i] = 1'b0;
        end
      end
    end
    if (rst) m_mode = boot_mode;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cmd_ready[%0d]", i), a_rdy[i], !m_vld[i] || rsp_ready);
        check($sformatf("rsp_valid[%0d]", i), a_vld[i], m_vld[i]);
        if (m_vld[i]) begin
          check($sformatf("rdata[%0d]", i), a_dat[i], m_dat[i]);
          check($sformatf("err[%0d]", i), a_err[i], m_err[i]);
        end
        check($sformatf("boot_done[%0d]", i), a_done[i], m_done[i]);
        check($sformatf("boot_mode_q[%0d]", i), a_mq[i], m_mode);
      end
      if (vld_a && rsp_ready) rsp_cnt++;
    end
  end

  task automatic send(input logic rd, input logic [11:0] a);
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = rdy_a;
      @(posedge clk); #1;
    end
    if (acc) cmd_cnt++;
    else begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: addr %h not accepted within 50 cycles", a);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1; boot_mode = m; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    do_reset(2'd0);
    chk_en = 1'b1;
    check("rst_cmd_ready", rdy_a, 1'b1);
    check("rst_rsp_valid", vld_a, 1'b0);
    check("rst_rdata", dat_a, 32'h0);
    check("rst_err", err_a, 1'b0);
    check("rst_boot_done", done_a, 1'b0);
    check("rst_rdata64", dat_c, 64'h0);

    send(1'b1, 12'h000);
    check("m0_w0", dat_a, 32'h8000_02b7);
    check("w64_beat0", dat_c, 64'h0002_8293_8000_02b7);
    send(1'b1, 12'h004);
    check("m0_w1", dat_a, 32'h0002_8293);
    send(1'b1, 12'h008);
    check("m0_w2", dat_a, 32'h0002_8067);
    check("done_before", done_a, 1'b0);
    idle();
    check("done_after", done_a, 1'b1);
    check("done_after64", done_c, 1'b1);
    send(1'b1, 12'h010);
    check("w64_oob_err", err_c, 1'b1);
    check("w64_oob_rdata", dat_c, 64'h0);
    check("w32_word4_err", err_a, 1'b0);
    idle();

    send(1'b0, 12'h000);
    check("wr_err", err_a, WR_ERR);
    check("wr_rdata", dat_a, 32'h0);
    send(1'b1, 12'h000);
    check("after_wr_w0", dat_a, 32'h8000_02b7);
    idle();

    cmd_cnt = 0; rsp_cnt = 0;
    rsp_ready = 1'b0;
    fork
      begin repeat (4) @(posedge clk); #1 rsp_ready = 1'b1; end
    join_none
    send(1'b1, 12'h000);
    check("bp_hold_data", dat_a, 32'h8000_02b7);
    check("bp_cmd_ready", rdy_a, 1'b0);
    send(1'b1, 12'h004);
    t0 = cyc_n;
    send(1'b1, 12'h008);
    send(1'b1, 12'h00c);
    check("bp_full_rate", 64'(cyc_n - t0), 64'd2);
    idle(); idle();
    check("bp_no_loss", 64'(rsp_cnt), 64'(cmd_cnt));

    rsp_ready = 1'b0;
    send(1'b1, 12'h004);
    rst = 1'b1; boot_mode = 2'd1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_vld", vld_a, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    send(1'b1, 12'h000);
    check("m1_w0", dat_a, 32'h2040_02b7);
    idle();

    do_reset(2'd2);
    send(1'b1, 12'h000);
    check("m2_w0", dat_b, 32'h0000_22b7);
    send(1'b1, 12'h004);
    check("m2_w1", dat_b, 32'h8002_8293);
    idle();

    do_reset(2'd3);
    send(1'b1, 12'h000);
    check("m3_w0", dat_a, 32'h0000_006f);
    send(1'b1, 12'h008);
    check("m3_w2", dat_a, 32'h0);
    idle();
    check("m3_no_done", done_a, 1'b0);
    boot_mode = 2'd1;
    repeat (3) idle();
    check("m3_strap_held", mq_a, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l524_bootrom_ctrl.md
# l524_bootrom_ctrl

- Parametrised boot ROM slave with an ICB command/response interface, a registered read path and a one-entry response buffer.
- Generates a three-instruction jump stub toward one of several boot targets, chosen by a `boot_mode` strap latched during reset.
- Reports errors on illegal accesses and raises a sticky `boot_done` once the core has fetched the final jump.
- Sits on the core's ROM window at reset-vector address and replaces a fixed-content mask ROM.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: byte-address width of the ROM window.
- `DATA_WIDTH`, 32: beat width; legal values are 32 or 64.
- `DATA_DEPTH`, 1024: number of 32-bit instruction words implemented.
- `ITCM_BASE`, 32'h8000_0000: target for boot_mode 0.
- `FLASH_BASE`, 32'h2040_0000: target for boot_mode 1.
- `ALT_BASE`, 32'h0000_0000: target for boot_mode 2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `boot_mode` in 2: boot strap.
- `icb_cmd_valid` in 1: command valid.
- `icb_cmd_ready` out 1: command accepted.
- `icb_cmd_addr` in ADDR_WIDTH: byte address.
- `icb_cmd_read` in 1: 1 = read, 0 = write.
- `icb_rsp_valid` out 1: response valid.
- `icb_rsp_ready` in 1: response accepted.
- `icb_rsp_rdata` out DATA_WIDTH: read data.
- `icb_rsp_err` out 1: bus error.
- `boot_done` out 1: sticky; set once the jump has been fetched.
- `boot_mode_q` out 2: latched strap.

## Operation
- **Strap latch:** `boot_mode_q` loads `boot_mode` on every cycle where `rst`=1. It holds its value after reset is released.
- **Boot target `T`:** selected by `boot_mode_q`, with `hi = T[31:12] + T[11]` (modulo 2^20).
- **ROM words, boot_mode_q = 0, 1 or 2:**
  - w0 = `(hi<<12) | 32'h2b7`, i.e. `lui t0, hi`.
  - w1 = `(T[11:0]<<20) | 32'h28293`, i.e. `addi t0, t0, lo`.
  - w2 = `32'h00028067`, i.e. `jr t0`.
  - All other words = 0.
- **ROM words, boot_mode_q = 3:** w0 = `32'h0000006f` (`j .`, park loop). All other words = 0.
- **Address decode:**
  - Word index = `addr[ADDR_WIDTH-1:2]`.
  - Beat index drops `log2(DATA_WIDTH/8)` low bits.
  - Sub-beat address bits are ignored.
- **64-bit beats:** word 2k goes on [31:0] and word 2k+1 on [63:32].
- **Out of range:** if any word in the beat has index >= `DATA_DEPTH`, return `rdata`=0 and `err`=1.
- **Writes:** ROM content is never modified (the error return is set by the Configuration macro).
- **Response buffer:** a single entry.
  - `icb_cmd_ready = !icb_rsp_valid || icb_rsp_ready`.
  - A command handshake loads `rdata`/`err` and sets `icb_rsp_valid` on the next edge.
  - A response handshake without a new command clears `icb_rsp_valid`.
- **boot_done:** set on the response handshake for the beat containing byte 0x8, when boot_mode_q ≠ 3 and err=0. It stays set until `rst`.

## Timing
- **Reset values:** `icb_rsp_valid`=0, `icb_rsp_rdata`=0, `icb_rsp_err`=0, `boot_done`=0. `icb_cmd_ready`=1 in the first cycle after reset.
- **Latency:** response is valid exactly 1 cycle after command acceptance.
- **Throughput:** 1 per cycle while `icb_rsp_ready`=1.
- **Backpressure:** `rdata`/`err` stay stable while `rsp_valid`=1 and `rsp_ready`=0. `cmd_ready`=0 during that time.
- **Simultaneous events:** a response handshake and a new command in the same cycle keep `rsp_valid`=1 and load the new data.
- **Reset mid-transaction:** a pending response is discarded. No stale response appears after reset.
- **Strap change after reset:** no effect until the next reset.

## Configuration
- Macro: `L524_BOOTROM_WR_ERR_EN`.
- **Defined:** a write command is acknowledged with `err`=1 and `rdata`=0.
- **Undefined:** a write is acknowledged with `err`=0 and `rdata`=0 (silent drop).
- Reads behave identically in both builds.

## Test plan
- **Mode 0 (default params):** reset with boot_mode=0, then read 0x0, 0x4, 0x8 → 0x800002b7, 0x00028293, 0x00028067. `boot_done` rises in the cycle after the 0x8 handshake.
- **Mode 1:** read 0x0 → 0x204002b7. **Mode 2 with ALT_BASE=0x1800:** read 0x0, 0x4 → 0x000022b7, 0x80028293 (T[11] carry).
- **Mode 3:** read 0x0 → 0x0000006f. A read of 0x8 returns 0 and `boot_done` stays 0. Changing boot_mode after reset leaves `boot_mode_q`=3.
- **DATA_WIDTH=64, DATA_DEPTH=4, mode 0:** read 0x0 → 0x00028293_800002b7. Read 0x10 → err=1, rdata=0.
- **Backpressure:** issue back-to-back reads with `rsp_ready` held 0 for 3 cycles. Data stays stable, `cmd_ready`=0, no command is lost, and full rate resumes afterwards.
- **Write to 0x0:** err=1 with the macro defined, err=0 without it. A later read still returns the original word. Asserting `rst` with a response pending → `rsp_valid`=0 next cycle.
